// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single backplane UART transmitter between two word sources:
// req0 carries ISA decode results, req1 carries host/PXIE messages.
// Grants alternate round-robin under contention. Only one word is in flight at a time.
// After each word, a minimum idle gap is enforced. An ACK timeout frees the
// channel if the transmitter never drops its ready level.
//
// Ports:
//   I_clk, I_Rst                 transmit-domain clock, asynchronous active-high reset
//   I_req0_data/vld, O_req0_rdy  requester 0 handshake (transfer on vld & rdy)
//   I_req1_data/vld, O_req1_rdy  requester 1 handshake
//   O_tx_data, O_tx_en           registered word and one-cycle start pulse to the transmitter
//   I_tx_ready                   transmitter idle level, low while shifting
//   O_grant                      one-hot owner of the word in flight, 00 when idle
//   O_busy                       not IDLE, or inter-word gap still counting
//   O_timeout_cnt                saturating count of words dropped for lack of an ACK
//
// state     | meaning
// IDLE      | waiting for an eligible requester; gap counter drains here
// ISSUE     | O_tx_en high for this cycle, word presented to the transmitter
// WAIT_ACK  | waiting for I_tx_ready to fall, bounded by ACK_TIMEOUT
// WAIT_DONE | transmitter shifting; waiting for I_tx_ready to return high

module uart_tx_arbiter #(
  parameter int DATA_W      = 64,
  parameter int MIN_GAP     = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              I_clk,
  input  logic              I_Rst,
  input  logic [DATA_W-1:0] I_req0_data,
  input  logic              I_req0_vld,
  output logic              O_req0_rdy,
  input  logic [DATA_W-1:0] I_req1_data,
  input  logic              I_req1_vld,
  output logic              O_req1_rdy,
  output logic [DATA_W-1:0] O_tx_data,
  output logic              O_tx_en,
  input  logic              I_tx_ready,
  output logic [1:0]        O_grant,
  output logic              O_busy,
  output logic [7:0]        O_timeout_cnt
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      ack_cnt;
  logic             ptr;       // 0: req0 wins a tie, 1: req1 wins a tie
  logic             eligible;
  logic             sel1;
  logic             take;

  // Ready is combinational so a requester is accepted in the same cycle it is
  // selected. A glitch low on I_tx_ready in IDLE only blocks eligibility.
  // Gating with I_Rst keeps both rdy outputs low while reset is held.
  always_comb begin
    eligible   = !I_Rst && (state == IDLE) && I_tx_ready && (gap_cnt == '0);
    sel1       = I_req1_vld && (!I_req0_vld || ptr);
    take       = eligible && (I_req0_vld || I_req1_vld);
    O_req0_rdy = take && !sel1;
    O_req1_rdy = take && sel1;
  end

  assign O_busy = (state != IDLE) || (gap_cnt != '0);

  always_ff @(posedge I_clk or posedge I_Rst) begin
    if (I_Rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      ack_cnt       <= '0;
      ptr           <= 1'b0;
      O_tx_data     <= '0;
      O_tx_en       <= 1'b0;
      O_grant       <= 2'b00;
      O_timeout_cnt <= 8'd0;
    end else begin
      O_tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (take) begin
            O_tx_data <= sel1 ? I_req1_data : I_req0_data;
            O_grant   <= sel1 ? 2'b10 : 2'b01;
            ptr       <= !sel1;  // next tie goes to the requester not just served
            O_tx_en   <= 1'b1;   // registered so the pulse lines up with ISSUE
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!I_tx_ready) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            // Transmitter never took the word: drop it and free the channel.
            if (O_timeout_cnt != 8'hFF) begin
              O_timeout_cnt <= O_timeout_cnt + 8'd1;
            end
            O_grant <= 2'b00;
            gap_cnt <= GAP_LOAD;
            state   <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (I_tx_ready) begin
            O_grant <= 2'b00;
            gap_cnt <= GAP_LOAD;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural reference model compared every cycle,
// directed scenarios with hand-computed expectations, and a randomized phase.

module tb_uart_tx_arbiter;
  localparam int DW  = 64;
  localparam int GAP = 2;
  localparam int ATO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;
  logic          v0 = 1'b0;
  logic          v1 = 1'b0;
  logic          rdy0, rdy1;
  logic [DW-1:0] tx_data;
  logic          tx_en;
  logic          tx_ready = 1'b1;
  logic [1:0]    grant;
  logic          busy;
  logic [7:0]    to_cnt;

  // second build: MIN_GAP=0, short ACK timeout
  logic [DW-1:0] g_d0 = '0;
  logic [DW-1:0] g_d1 = '0;
  logic          g_v0 = 1'b0;
  logic          g_v1 = 1'b0;
  logic          g_rdy0, g_rdy1;
  logic [DW-1:0] g_txd;
  logic          g_txen;
  logic          g_ready = 1'b1;
  logic [1:0]    g_grant;
  logic          g_busy;
  logic [7:0]    g_to;

  int checks = 0;
  int errors = 0;

  // transmitter model controls
  int xmt_ack    = 3;
  int xmt_len    = 100;
  bit xmt_noack  = 1'b0;
  bit xmt_force  = 1'b0;
  bit xmt_glitch = 1'b0;

  uart_tx_arbiter #(.DATA_W(DW), .MIN_GAP(GAP), .ACK_TIMEOUT(ATO)) dut (
    .I_clk(clk), .I_Rst(rst),
    .I_req0_data(d0), .I_req0_vld(v0), .O_req0_rdy(rdy0),
    .I_req1_data(d1), .I_req1_vld(v1), .O_req1_rdy(rdy1),
    .O_tx_data(tx_data), .O_tx_en(tx_en), .I_tx_ready(tx_ready),
    .O_grant(grant), .O_busy(busy), .O_timeout_cnt(to_cnt)
  );

  uart_tx_arbiter #(.DATA_W(DW), .MIN_GAP(0), .ACK_TIMEOUT(4)) u_g0 (
    .I_clk(clk), .I_Rst(rst),
    .I_req0_data(g_d0), .I_req0_vld(g_v0), .O_req0_rdy(g_rdy0),
    .I_req1_data(g_d1), .I_req1_vld(g_v1), .O_req1_rdy(g_rdy1),
    .O_tx_data(g_txd), .O_tx_en(g_txen), .I_tx_ready(g_ready),
    .O_grant(g_grant), .O_busy(g_busy), .O_timeout_cnt(g_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: after a start pulse, ready falls xmt_ack cycles later and stays
  // low for xmt_len cycles. Optional single-cycle glitches while not shifting.
  initial begin
    int xt;
    bit xact;
    bit glitch;
    xt = 0;
    xact = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tx_en) begin
        xt = 0;
        xact = !xmt_noack;
      end else if (xact) begin
        xt++;
        if (xt >= xmt_ack + xmt_len) xact = 1'b0;
      end
      glitch = !xact && xmt_glitch && ($urandom_range(0, 7) == 0);
      tx_ready = !(xmt_force || glitch || (xact && xt >= xmt_ack));
    end
  end

  // Reference model: owner of the word in flight (-1 none), whether the start
  // pulse is due, whether the transmitter has acknowledged, cycles waited,
  // remaining gap, tie preference and timeout tally.
  int            m_owner = -1;
  bit            m_issue = 1'b0;
  bit            m_acked = 1'b0;
  int            m_wait  = 0;
  int            m_gap   = 0;
  int            m_pref  = 0;
  int            m_to    = 0;
  logic [DW-1:0] m_data  = '0;

  initial begin
    int sel;
    bit elig;
    logic [1:0] eg;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_owner = -1; m_issue = 1'b0; m_acked = 1'b0; m_wait = 0;
        m_gap = 0; m_pref = 0; m_to = 0; m_data = '0;
      end
      elig = !rst && (m_owner < 0) && tx_ready && (m_gap == 0);
      sel = -1;
      if (v0 && v1) sel = m_pref;
      else if (v0) sel = 0;
      else if (v1) sel = 1;
      eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      chk("rdy0", 64'(rdy0), 64'(elig && sel == 0));
      chk("rdy1", 64'(rdy1), 64'(elig && sel == 1));
      chk("tx_en", 64'(tx_en), 64'(m_issue));
      chk("tx_data", 64'(tx_data), 64'(m_data));
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'((m_owner >= 0) || (m_gap > 0)));
      chk("timeout_cnt", 64'(to_cnt), 64'(m_to));
      if (!rst) begin
        if (m_owner < 0) begin
          if (m_gap > 0) m_gap--;
          else if (elig && sel >= 0) begin
            m_owner = sel;
            m_data  = (sel == 1) ? d1 : d0;
            m_pref  = 1 - sel;
            m_issue = 1'b1;
          end
        end else if (m_issue) begin
          m_issue = 1'b0; m_acked = 1'b0; m_wait = 0;
        end else if (!m_acked) begin
          if (!tx_ready) m_acked = 1'b1;
          else begin
            m_wait++;
            if (m_wait >= ATO) begin
              m_to = (m_to < 255) ? m_to + 1 : 255;
              m_owner = -1;
              m_gap = GAP;
            end
          end
        end else if (tx_ready) begin
          m_owner = -1;
          m_gap = GAP;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // which: 0 tx_en high, 1 ready low, 2 ready high, 3 rdy0 high, 4 timeout count nonzero
  task automatic wait_sig(input string name, input int which, input int limit, output int waited);
    bit hit;
    hit = 1'b0;
    waited = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = tx_en;
        1: hit = !tx_ready;
        2: hit = tx_ready;
        3: hit = rdy0;
        default: hit = (to_cnt != 8'd0);
      endcase
      if (hit) begin
        waited = i;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: no event within %0d cycles, required event", name, limit);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit bad;
    logic [63:0] ord_d [4];
    logic [1:0]  ord_g [4];
    logic [63:0] word_a, word_b;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single word, then gap after DONE
    xmt_ack = 3; xmt_len = 100;
    v0 = 1'b1; d0 = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("t1_rdy0_same_cycle", 64'(rdy0), 64'd1);
    tick();
    v0 = 1'b0;
    @(negedge clk);
    chk("t1_tx_en", 64'(tx_en), 64'd1);
    chk("t1_tx_data", tx_data, 64'h0123_4567_89AB_CDEF);
    chk("t1_grant", 64'(grant), 64'(2'b01));
    tick();
    v0 = 1'b1; d0 = 64'h1111_2222_3333_4444;
    wait_sig("t1_ack", 1, 10, w);
    wait_sig("t1_done", 2, 150, w);
    wait_sig("t1_gap", 3, 10, w);
    chk("t1_gap_cycles", 64'(w), 64'd2);
    tick();
    v0 = 1'b0;
    wait_sig("t1_en2", 0, 5, w);
    chk("t1_tx_data2", tx_data, 64'h1111_2222_3333_4444);
    wait_sig("t1_ack2", 1, 10, w);
    wait_sig("t1_done2", 2, 150, w);

    // contention: alternate A,B,A,B
    pulse_reset();
    word_a = 64'hAAAA_0000_AAAA_0001;
    word_b = 64'hBBBB_0000_BBBB_0002;
    ord_d[0] = word_a; ord_d[1] = word_b; ord_d[2] = word_a; ord_d[3] = word_b;
    ord_g[0] = 2'b01;  ord_g[1] = 2'b10;  ord_g[2] = 2'b01;  ord_g[3] = 2'b10;
    xmt_ack = 2; xmt_len = 50;
    v0 = 1'b1; v1 = 1'b1; d0 = word_a; d1 = word_b;
    for (int i = 0; i < 4; i++) begin
      wait_sig("t2_en", 0, 120, w);
      chk("t2_order_data", tx_data, ord_d[i]);
      chk("t2_order_grant", 64'(grant), 64'(ord_g[i]));
    end
    tick();
    v0 = 1'b0; v1 = 1'b0;
    wait_sig("t2_ack", 1, 10, w);
    wait_sig("t2_done", 2, 100, w);

    // ACK timeout with ACK_TIMEOUT=255
    pulse_reset();
    xmt_noack = 1'b1;
    v1 = 1'b1; d1 = 64'hDEAD_BEEF_0000_0001;
    wait_sig("t3_en", 0, 10, w);
    tick();
    v1 = 1'b0;
    wait_sig("t3_timeout", 4, 300, w);
    chk("t3_timeout_latency", 64'(w), 64'd255);
    chk("t3_timeout_cnt", 64'(to_cnt), 64'd1);
    chk("t3_grant_cleared", 64'(grant), 64'd0);
    chk("t3_busy_in_gap", 64'(busy), 64'd1);
    tick();
    xmt_noack = 1'b0;

    // blocked transmitter
    pulse_reset();
    xmt_force = 1'b1;
    v0 = 1'b1; d0 = 64'h5555_6666_7777_8888;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy0 || tx_en) bad = 1'b1;
    end
    chk("t4_blocked", 64'(bad), 64'd0);
    tick();
    xmt_force = 1'b0;
    @(negedge clk);
    chk("t4_rdy0_on_release", 64'(rdy0), 64'd1);
    tick();
    v0 = 1'b0;
    @(negedge clk);
    chk("t4_tx_en", 64'(tx_en), 64'd1);
    chk("t4_tx_data", tx_data, 64'h5555_6666_7777_8888);
    wait_sig("t4_ack", 1, 10, w);
    wait_sig("t4_done", 2, 100, w);

    // asynchronous reset in WAIT_DONE
    pulse_reset();
    xmt_ack = 3; xmt_len = 100;
    v0 = 1'b1; d0 = 64'h0BAD_F00D_0BAD_F00D;
    wait_sig("t5_en", 0, 10, w);
    tick();
    v0 = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_grant", 64'(grant), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    chk("t5_async_tx_en", 64'(tx_en), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    d0 = 64'h0000_0000_0000_00A0; d1 = 64'h0000_0000_0000_00B1;
    wait_sig("t5_en2", 0, 150, w);
    chk("t5_ptr_favours_req0", 64'(grant), 64'(2'b01));
    tick();
    v0 = 1'b0; v1 = 1'b0;
    wait_sig("t5_ack", 1, 10, w);
    wait_sig("t5_done", 2, 150, w);

    // randomized traffic against the model
    pulse_reset();
    xmt_glitch = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c % 64 == 0) begin
        xmt_ack   = $urandom_range(1, 6);
        xmt_len   = $urandom_range(1, 30);
        xmt_noack = ($urandom_range(0, 5) == 0);
      end
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
    end
    tick();
    v0 = 1'b0; v1 = 1'b0; xmt_noack = 1'b0; xmt_glitch = 1'b0;
    repeat (300) tick();

    // MIN_GAP=0 build: back-to-back words, then timeout saturation
    pulse_reset();
    g_v0 = 1'b1; g_d0 = 64'hC0DE_0000_0000_0001; g_ready = 1'b1;
    @(negedge clk);
    chk("g0_rdy0_first", 64'(g_rdy0), 64'd1);
    chk("g0_rdy1_idle", 64'(g_rdy1), 64'd0);
    tick();
    g_d0 = 64'hC0DE_0000_0000_0002;
    @(negedge clk);
    chk("g0_tx_en1", 64'(g_txen), 64'd1);
    chk("g0_tx_data1", g_txd, 64'hC0DE_0000_0000_0001);
    chk("g0_grant1", 64'(g_grant), 64'(2'b01));
    tick();
    g_ready = 1'b0;
    repeat (5) tick();
    g_ready = 1'b1;
    @(negedge clk);
    chk("g0_rdy0_while_done", 64'(g_rdy0), 64'd0);
    tick();
    @(negedge clk);
    chk("g0_rdy0_after_done", 64'(g_rdy0), 64'd1);
    tick();
    @(negedge clk);
    chk("g0_tx_en2", 64'(g_txen), 64'd1);
    chk("g0_tx_data2", g_txd, 64'hC0DE_0000_0000_0002);
    repeat (4) @(negedge clk);
    chk("g0_no_timeout_yet", 64'(g_to), 64'd0);
    @(negedge clk);
    chk("g0_first_timeout", 64'(g_to), 64'd1);
    repeat (6 * 300) @(negedge clk);
    chk("g0_timeout_saturated", 64'(g_to), 64'd255);
    tick();
    g_v0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("g0_idle_grant", 64'(g_grant), 64'd0);
    chk("g0_idle_busy", 64'(g_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single backplane UART transmitter (64-bit word, valid-pulse in, tx_ready level out) between two 64-bit word sources: req0 = ISA decode result path, req1 = host/PXIE-originated messages.
- Round-robin grant, one word in flight, ACK/DONE tracking of the transmitter's ready level, minimum inter-word gap, and an ACK timeout that recovers the channel if the transmitter never responds.
- Sits between the word producers and the UART TX block, in the UART transmit clock domain.

Parameters:
- DATA_W, 64, word width of requesters and transmitter.
- MIN_GAP, 2, idle cycles enforced after DONE before the next grant (0 allowed).
- ACK_TIMEOUT, 255, cycles to wait for I_tx_ready to fall after O_tx_en; must be ≥1 and fit in 16 bits.

Ports:
- I_clk  in  1  transmit-domain clock.
- I_Rst  in  1  asynchronous reset, active-high.
- I_req0_data  in  DATA_W  requester 0 word.
- I_req0_vld  in  1  requester 0 word valid; held until accepted.
- O_req0_rdy  out  1  requester 0 accept; transfer when vld&rdy.
- I_req1_data  in  DATA_W  requester 1 word.
- I_req1_vld  in  1  requester 1 word valid.
- O_req1_rdy  out  1  requester 1 accept.
- O_tx_data  out  DATA_W  word to transmitter, registered, stable from ISSUE until the next accept.
- O_tx_en  out  1  one-cycle start pulse to transmitter.
- I_tx_ready  in  1  transmitter idle level; low while shifting.
- O_grant  out  2  one-hot owner of the word in flight; 00 when idle.
- O_busy  out  1  high in any state other than IDLE, and during the gap.
- O_timeout_cnt  out  8  saturating count of ACK timeouts.

Behaviour:
- Reset (asynchronous, active-high) values: state=IDLE, O_tx_en=0, O_tx_data=0, O_grant=00, O_busy=0, O_timeout_cnt=0, gap counter=0, round-robin pointer=req0-first; rdy outputs 0.
- IDLE:
  - Eligible when I_tx_ready=1 and the gap counter is 0.
  - If both vld are high, grant the requester the pointer selects; if one is high, grant it.
  - O_reqN_rdy is combinational: high only for the selected requester while eligible.
  - On the transfer cycle: capture data into O_tx_data, set O_grant, flip the pointer to favour the other requester, go to ISSUE.
  - If I_tx_ready=0, stay in IDLE with no rdy.
- ISSUE: O_tx_en=1 for exactly this cycle. Clear the timeout counter and go to WAIT_ACK. Latency from accept cycle to O_tx_en is 1 cycle.
- WAIT_ACK:
  - I_tx_ready=0 → go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches ACK_TIMEOUT: O_timeout_cnt+1 (saturate at 255), O_grant=00, load the gap counter with MIN_GAP, go to IDLE. The word is discarded, not retried.
- WAIT_DONE:
  - I_tx_ready=1 → O_grant=00, load the gap counter with MIN_GAP, go to IDLE.
  - There is no timeout in this state.
- Gap counter: decrements by 1 per cycle in IDLE while nonzero; no grant while nonzero. MIN_GAP=0 allows a grant on the cycle after DONE.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…; the pointer advances only on a grant.
- A requester dropping vld before it is accepted is legal; no transfer occurs. A requester changing data while vld=1 and rdy=0 is legal; the value on the accept cycle is used.
- I_tx_ready glitching low in IDLE only blocks eligibility; it is not treated as an ACK.
- Reset mid-word: all state clears immediately and O_tx_en drops. The in-flight word is lost, and the transmitter is allowed to finish on its own.

Test Plan:
- Single word: reset, I_tx_ready=1, req0 vld data=64'h0123_4567_89AB_CDEF → rdy0 high same cycle, O_tx_en pulse next cycle with that data, O_grant=01. Model drops ready 3 cycles later and raises it 100 cycles later → IDLE; next grant no earlier than 2 cycles after ready rises.
- Contention: both vld continuous, req0 data=A, req1 data=B, transmitter model 50-cycle frame → transmitted order A,B,A,B for 4 words; O_grant 01,10,01,10.
- ACK timeout: req1 word, I_tx_ready held 1 → O_tx_en once; 255 cycles later O_timeout_cnt=1, back to IDLE; repeat 300 times → O_timeout_cnt saturates at 255.
- Blocked transmitter: I_tx_ready=0, req0 vld → rdy0 stays 0, no O_tx_en; raise ready → accept on the first eligible cycle.
- Reset in WAIT_DONE: assert I_Rst asynchronously mid-frame → O_grant=00, O_busy=0, O_tx_en=0 without waiting for a clock; after release the pointer favours req0.
- MIN_GAP=0 build: back-to-back req0 words → second accept on the cycle after I_tx_ready returns high.
